// File: rtl/id_stage_reg.sv
// IF/ID boundary register: two-entry skid buffer with a
// registered if_ready and immediate-format pre-decode.

package id_stage_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b110,
    IMM_NONE = 3'b111
  } imm_sel_e;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    imm_sel_e    imm_sel;
    logic        illegal;
  } if_id_t;

  localparam if_id_t IF_ID_RST = '{
    pc:      32'h0,
    inst:    NOP,
    imm_sel: IMM_I,
    illegal: 1'b0
  };

endpackage

module id_stage_reg
  import id_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_inst,
  output logic [2:0]      id_imm_sel,
  output logic            id_illegal
);

  occ_e   state_q;
  occ_e   state_d;
  if_id_t main_q;
  if_id_t skid_q;
  if_id_t cap;
  logic   if_ready_q;
  logic   in_xfer;
  logic   out_xfer;
  logic   ld_main_in;
  logic   ld_main_skid;
  logic   ld_skid;
  logic [6:0] opc;

  assign id_valid = (state_q != S_EMPTY);
  assign if_ready = if_ready_q;
  assign in_xfer  = if_valid && if_ready_q;
  assign out_xfer = id_valid && id_ready;

  assign opc = if_inst[6:0];

  // Pre-decode at capture so id_imm_sel is a flop output.
  always_comb begin
    cap.pc      = 32'(if_pc);
    cap.inst    = if_inst;
    cap.imm_sel = IMM_NONE;
    cap.illegal = 1'b1;
    unique case (1'b1)
      (if_inst[1:0] != 2'b11): begin
        cap.imm_sel = IMM_NONE;
        cap.illegal = 1'b1;
      end
      (opc == OP_LOAD),
      (opc == OP_OPIMM),
      (opc == OP_JALR),
      (opc == OP_MISC),
      (opc == OP_SYSTEM): begin
        cap.imm_sel = IMM_I;
        cap.illegal = 1'b0;
      end
      (opc == OP_STORE): begin
        cap.imm_sel = IMM_S;
        cap.illegal = 1'b0;
      end
      (opc == OP_BRANCH): begin
        cap.imm_sel = IMM_B;
        cap.illegal = 1'b0;
      end
      (opc == OP_LUI),
      (opc == OP_AUIPC): begin
        cap.imm_sel = IMM_U;
        cap.illegal = 1'b0;
      end
      (opc == OP_JAL): begin
        cap.imm_sel = IMM_J;
        cap.illegal = 1'b0;
      end
      (opc == OP_OP): begin
        cap.imm_sel = IMM_NONE;
        cap.illegal = 1'b0;
      end
      default: begin
        cap.imm_sel = IMM_NONE;
        cap.illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      if_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      if_ready_q <= (state_d != S_FULL);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (in_xfer) state_d = S_ONE;
      end
      S_ONE: begin
        if (out_xfer && !in_xfer)
          state_d = S_EMPTY;
        else if (in_xfer && !out_xfer)
          state_d = S_FULL;
      end
      S_FULL: begin
        if (out_xfer) state_d = S_ONE;
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
  end

  always_comb begin
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      S_EMPTY: ld_main_in = in_xfer;
      S_ONE: begin
        ld_main_in = in_xfer && out_xfer;
        ld_skid    = in_xfer && !out_xfer;
      end
      S_FULL: ld_main_skid = out_xfer;
      default: ;
    endcase
    // Redirect drops everything, including this cycle's input.
    if (flush) begin
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= IF_ID_RST;
      skid_q <= IF_ID_RST;
    end else begin
      if (ld_main_in)
        main_q <= cap;
      else if (ld_main_skid)
        main_q <= skid_q;
      if (ld_skid)
        skid_q <= cap;
    end
  end

  assign id_pc      = main_q.pc[XLEN-1:0];
  assign id_inst    = main_q.inst;
  assign id_imm_sel = main_q.imm_sel;
  assign id_illegal = main_q.illegal;

endmodule

// File: tb/tb_id_stage_reg.sv
// Directed and random checks of id_stage_reg against a
// queue scoreboard of expected decode-stage entries.

module tb_id_stage_reg;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  sel;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  id_imm_sel;
  logic        id_illegal;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t shadow;

  always #5 clk = ~clk;

  id_stage_reg #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_imm_sel (id_imm_sel),
    .id_illegal (id_illegal)
  );

  function automatic exp_t mk(input logic [31:0] pc,
                              input logic [31:0] inst);
    exp_t e;
    e.pc   = pc;
    e.inst = inst;
    e.sel  = 3'b111;
    e.ill  = 1'b1;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:2])
        5'b00000, 5'b00100, 5'b11001,
        5'b00011, 5'b11100: begin e.sel = 3'b000; e.ill = 1'b0; end
        5'b01000: begin e.sel = 3'b001; e.ill = 1'b0; end
        5'b11000: begin e.sel = 3'b010; e.ill = 1'b0; end
        5'b01101, 5'b00101: begin e.sel = 3'b011; e.ill = 1'b0; end
        5'b11011: begin e.sel = 3'b110; e.ill = 1'b0; end
        5'b01100: begin e.sel = 3'b111; e.ill = 1'b0; end
        default: begin e.sel = 3'b111; e.ill = 1'b1; end
      endcase
    end
    return e;
  endfunction

  function automatic exp_t rst_val();
    exp_t e;
    e.pc   = 32'h0;
    e.inst = 32'h0000_0013;
    e.sel  = 3'b000;
    e.ill  = 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".if_ready"}, 32'(if_ready), 32'(sb.size() < 2));
    chk({tag, ".id_valid"}, 32'(id_valid), 32'(sb.size() > 0));
    chk({tag, ".id_pc"}, id_pc, shadow.pc);
    chk({tag, ".id_inst"}, id_inst, shadow.inst);
    chk({tag, ".id_imm_sel"}, 32'(id_imm_sel), 32'(shadow.sel));
    chk({tag, ".id_illegal"}, 32'(id_illegal), 32'(shadow.ill));
  endtask

  // One clock: drive, advance the model at the edge, check at negedge.
  task automatic cyc(input logic v, input logic [31:0] pc,
                     input logic [31:0] inst, input logic rdy,
                     input logic fl, input logic rs,
                     input string tag);
    bit acc;
    bit con;
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    id_ready = rdy;
    flush    = fl;
    rst      = rs;
    acc = v && (sb.size() < 2);
    con = (sb.size() > 0) && rdy;
    @(posedge clk);
    if (rs) begin
      sb.delete();
      shadow = rst_val();
    end else if (fl) begin
      sb.delete();
    end else begin
      if (con) void'(sb.pop_front());
      if (acc) sb.push_back(mk(pc, inst));
    end
    if (sb.size() > 0) shadow = sb[0];
    @(negedge clk);
    check_all(tag);
  endtask

  logic [6:0] ops [12] = '{
    7'h03, 7'h13, 7'h67, 7'h0f, 7'h73, 7'h23,
    7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h0b
  };

  initial begin
    logic [31:0] r;
    logic [31:0] pc;
    int          k;
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0;
    if_pc = '0; if_inst = '0; id_ready = 1'b0;
    shadow = rst_val();

    cyc(0, 0, 0, 0, 0, 1, "rst0");
    cyc(0, 0, 0, 0, 0, 1, "rst1");
    chk("rst.id_inst", id_inst, 32'h0000_0013);
    chk("rst.if_ready", 32'(if_ready), 32'd1);

    cyc(1, 32'h100, 32'h0050_0093, 1, 0, 0, "addi");
    chk("addi.sel", 32'(id_imm_sel), 32'd0);
    cyc(1, 32'h104, 32'h0011_2223, 1, 0, 0, "sw");
    chk("sw.sel", 32'(id_imm_sel), 32'd1);
    cyc(1, 32'h108, 32'hFE00_0EE3, 1, 0, 0, "beq");
    chk("beq.sel", 32'(id_imm_sel), 32'd2);
    chk("beq.if_ready", 32'(if_ready), 32'd1);

    cyc(1, 32'h10c, 32'h1234_50B7, 1, 0, 0, "lui");
    chk("lui.sel", 32'(id_imm_sel), 32'd3);
    cyc(1, 32'h110, 32'h0080_006F, 1, 0, 0, "jal");
    chk("jal.sel", 32'(id_imm_sel), 32'd6);
    cyc(1, 32'h114, 32'h0020_81B3, 1, 0, 0, "add");
    chk("add.sel", 32'(id_imm_sel), 32'd7);
    chk("add.ill", 32'(id_illegal), 32'd0);
    cyc(1, 32'h118, 32'hFFFF_FFFF, 1, 0, 0, "ones");
    chk("ones.ill", 32'(id_illegal), 32'd1);
    cyc(1, 32'h11c, 32'h0000_0000, 1, 0, 0, "zero");
    chk("zero.ill", 32'(id_illegal), 32'd1);
    cyc(0, 0, 0, 1, 0, 0, "drain0");

    cyc(1, 32'h200, 32'h0010_0093, 0, 0, 0, "bp.a");
    cyc(1, 32'h204, 32'h0020_0093, 0, 0, 0, "bp.b");
    chk("bp.if_ready", 32'(if_ready), 32'd0);
    cyc(1, 32'h208, 32'h0030_0093, 0, 0, 0, "bp.hold");
    chk("bp.hold_a", id_inst, 32'h0010_0093);
    cyc(1, 32'h208, 32'h0030_0093, 1, 0, 0, "bp.outa");
    chk("bp.b_out", id_inst, 32'h0020_0093);
    cyc(1, 32'h208, 32'h0030_0093, 1, 0, 0, "bp.outb");
    chk("bp.c_out", id_inst, 32'h0030_0093);
    cyc(0, 0, 0, 1, 0, 0, "bp.outc");

    cyc(1, 32'h300, 32'h0010_0093, 0, 0, 0, "fl.a");
    cyc(1, 32'h304, 32'h0020_0093, 0, 0, 0, "fl.b");
    cyc(1, 32'h308, 32'h0030_0093, 0, 1, 0, "fl.flush");
    chk("fl.id_valid", 32'(id_valid), 32'd0);
    chk("fl.if_ready", 32'(if_ready), 32'd1);
    cyc(1, 32'h30c, 32'h0040_0093, 1, 0, 0, "fl.d");
    chk("fl.d_inst", id_inst, 32'h0040_0093);
    cyc(0, 0, 0, 1, 0, 0, "fl.drain");

    cyc(1, 32'h400, 32'h0010_0093, 0, 0, 0, "mr.a");
    cyc(1, 32'h404, 32'h0020_0093, 0, 0, 0, "mr.b");
    cyc(1, 32'h408, 32'h0030_0093, 0, 0, 1, "mr.rst");
    chk("mr.id_pc", id_pc, 32'h0);
    chk("mr.id_inst", id_inst, 32'h0000_0013);
    cyc(1, 32'h500, 32'h0010_0093, 0, 0, 0, "rf.a");
    cyc(1, 32'h504, 32'h0020_0093, 0, 0, 0, "rf.b");
    cyc(1, 32'h508, 32'h0030_0093, 0, 1, 1, "rf.both");
    chk("rf.id_inst", id_inst, 32'h0000_0013);
    chk("rf.if_ready", 32'(if_ready), 32'd1);

    pc = 32'h1000;
    for (int i = 0; i < 10000; i++) begin
      r = $urandom;
      k = $urandom_range(0, 12);
      if (k < 12) r[6:0] = ops[k];
      cyc(($urandom_range(0, 9) < 7), pc, r,
          ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 99) == 0), 1'b0, "rand");
      pc = pc + 32'd4;
    end
    cyc(0, 0, 0, 1, 0, 0, "end0");
    cyc(0, 0, 0, 1, 0, 0, "end1");
    cyc(0, 0, 0, 1, 0, 0, "end2");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
